dcp_tx_printer: RTL and testbench

Responder side of the debug-unit transmit request interface. A command module (register dump, memory dump) raises `req_tx` with a 32-bit word and a format type. This block serialises the request into ASCII bytes for the UART transmitter through a valid/ready byte handshake. It completes the request with a four-phase `ack_tx`. It sits between the debug control processor's command modules and the UART TX core.

---
 rtl/dcp_tx_printer.sv | 113 +++++++++++
 tb/tb_dcp_tx_printer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dcp_tx_printer.sv
// Debug-unit transmit printer: turns one request word into a raw byte, hex text
// and/or CR-LF, streamed over a valid/ready byte port, closed by a four-phase ack.
module dcp_tx_printer #(
  parameter int unsigned UPPER_HEX = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic [1:0]  type_tx,
  input  logic [31:0] dout,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  idx_q, idx_d;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] base;
    if (nib < 4'd10) begin
      hex_char = 8'h30 + {4'h0, nib};
    end else begin
      base     = (UPPER_HEX != 0) ? 8'h41 : 8'h61;
      hex_char = base + {4'h0, nib} - 8'd10;
    end
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] t);
    case (t)
      2'b00:   last_idx = 4'd0;
      2'b01:   last_idx = 4'd7;
      2'b10:   last_idx = 4'd9;
      default: last_idx = 4'd1;
    endcase
  endfunction

  // Byte [idx] of the captured request; hex digits run MSB nibble first.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] t,
                                          input logic [3:0] i);
    logic [4:0] lsb;
    logic [7:0] hx;
    lsb = {3'd7 - i[2:0], 2'b00};
    hx  = hex_char(w[lsb +: 4]);
    case (t)
      2'b00:   byte_sel = w[7:0];
      2'b01:   byte_sel = hx;
      2'b10:   byte_sel = (i < 4'd8) ? hx : ((i == 4'd8) ? 8'h0D : 8'h0A);
      default: byte_sel = (i == 4'd0) ? 8'h0D : 8'h0A;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    type_d  = type_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (req_tx) begin
          word_d  = dout;
          type_d  = type_tx;
          idx_d   = 4'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (rdy_tx) begin
          if (idx_q == last_idx(type_q)) begin
            state_d = S_ACK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (!req_tx) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      word_q  <= 32'h0;
      type_q  <= 2'b00;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      type_q  <= type_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only, so d_tx is frozen while a byte stalls.
  assign vld_tx = (state_q == S_SEND);
  assign ack_tx = (state_q == S_ACK);
  assign d_tx   = vld_tx ? byte_sel(word_q, type_q, idx_q) : 8'h00;

endmodule

// File: tb/tb_dcp_tx_printer.sv
// Scoreboard bench for dcp_tx_printer: stimulus queues expected bytes and control
// observations, one negedge monitor process does all comparing and counting.
module tb_dcp_tx_printer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_tx, req_l, rdy_tx;
  logic [1:0]  type_tx;
  logic [31:0] dout;
  logic        ack_tx, vld_tx, ack_l, vld_l;
  logic [7:0]  d_tx, d_l;

  always #5 clk = ~clk;

  dcp_tx_printer #(.UPPER_HEX(1)) dut (
    .clk(clk), .rstn(rstn), .req_tx(req_tx), .type_tx(type_tx), .dout(dout),
    .ack_tx(ack_tx), .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx)
  );

  dcp_tx_printer #(.UPPER_HEX(0)) dut_lc (
    .clk(clk), .rstn(rstn), .req_tx(req_l), .type_tx(type_tx), .dout(dout),
    .ack_tx(ack_l), .d_tx(d_l), .vld_tx(vld_l), .rdy_tx(rdy_tx)
  );

  logic [7:0]  exp_q[$];
  string       nm_q[$];
  logic [31:0] got_q[$];
  logic [31:0] want_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] w);
    nm_q.push_back(nm);
    got_q.push_back(g);
    want_q.push_back(w);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_hex8_tail(input logic [7:0] last);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h30);
    exp_q.push_back(last);
  endtask

  // Monitor: deferred control checks, byte scoreboard, stall-hold rule, end of run.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  int         cycles = 0;

  always @(negedge clk) begin
    string       s;
    logic [31:0] g, w;
    logic [7:0]  e;
    cycles++;
    while (nm_q.size() > 0) begin
      s = nm_q.pop_front();
      g = got_q.pop_front();
      w = want_q.pop_front();
      n_cmp++;
      if (g !== w) begin
        n_err++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", s, g, w);
      end
    end
    if (rstn && prev_stall) begin
      n_cmp++;
      if (vld_tx !== 1'b1 || d_tx !== prev_d) begin
        n_err++;
        $display("FAIL stall_hold: got vld=%b d=0x%02h, expected vld=1 d=0x%02h", vld_tx, d_tx, prev_d);
      end
    end
    if (rstn && vld_tx && rdy_tx) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_byte: got 0x%02h, expected no byte", d_tx);
      end else begin
        e = exp_q.pop_front();
        if (d_tx !== e) begin
          n_err++;
          $display("FAIL byte: got 0x%02h, expected 0x%02h", d_tx, e);
        end
      end
    end
    prev_stall = rstn && vld_tx && !rdy_tx;
    prev_d     = d_tx;
    if (done) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL missing_bytes: got %0d left over, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
    if (cycles > 20000) begin
      $display("FAIL timeout: got %0d cycles, expected completion", cycles);
      $fatal(1, "bench timeout");
    end
  end

  // Called just after a posedge with the DUT idle; ends idle again.
  task automatic run_req(input logic [1:0] t, input logic [31:0] w, input bit stall,
                         input int hold, input int drop_at, input int nbytes);
    int n;
    req_tx  = 1'b1;
    type_tx = t;
    dout    = w;
    rdy_tx  = 1'b1;
    cyc(1);
    chk("vld_after_capture", {30'b0, ack_tx, vld_tx}, 32'h1);
    dout    = 32'hFFFF_FFFF;
    type_tx = ~t;
    n = 0;
    while (ack_tx !== 1'b1 && n < 64) begin
      if (stall) rdy_tx = ~rdy_tx;
      if (n == drop_at) req_tx = 1'b0;
      cyc(1);
      n++;
    end
    chk("ack_rise", {31'b0, ack_tx}, 32'h1);
    if (!stall) chk("ack_latency", n, nbytes);
    rdy_tx = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cyc(1);
      chk("ack_hold", {30'b0, ack_tx, vld_tx}, 32'h2);
    end
    req_tx = 1'b0;
    cyc(1);
    chk("ack_fall", {31'b0, ack_tx}, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; req_tx = 1'b0; req_l = 1'b0; rdy_tx = 1'b0;
    type_tx = 2'b00; dout = 32'h0;
    cyc(3);
    chk("reset_outputs", {22'b0, ack_tx, vld_tx, d_tx}, 32'h0);
    rstn = 1'b1;
    cyc(2);

    push_hex8_tail(8'h35);
    exp_q[6] = 8'h41;
    run_req(2'b01, 32'h0000_00A5, 1'b0, 0, -1, 8);

    exp_q.push_back(8'h44); exp_q.push_back(8'h45); exp_q.push_back(8'h41);
    exp_q.push_back(8'h44); exp_q.push_back(8'h42); exp_q.push_back(8'h45);
    exp_q.push_back(8'h45); exp_q.push_back(8'h46); exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    run_req(2'b10, 32'hDEAD_BEEF, 1'b1, 0, -1, 10);

    exp_q.push_back(8'h54);
    run_req(2'b00, 32'h1234_5654, 1'b0, 0, -1, 1);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    run_req(2'b11, 32'h0000_0000, 1'b0, 0, -1, 2);

    push_hex8_tail(8'h31);
    run_req(2'b01, 32'h0000_0001, 1'b0, 0, -1, 8);
    push_hex8_tail(8'h33);
    run_req(2'b01, 32'h0000_0003, 1'b0, 0, 2, 8);

    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    run_req(2'b11, 32'h0000_0000, 1'b0, 5, -1, 2);
    push_hex8_tail(8'h34);
    run_req(2'b01, 32'h0000_0004, 1'b0, 0, -1, 8);

    exp_q.push_back(8'h31); exp_q.push_back(8'h32); exp_q.push_back(8'h33);
    req_tx = 1'b1; type_tx = 2'b01; dout = 32'h1234_5678; rdy_tx = 1'b1;
    cyc(1);
    dout = 32'hFFFF_FFFF;
    cyc(3);
    rstn = 1'b0;
    #1;
    chk("reset_async", {22'b0, ack_tx, vld_tx, d_tx}, 32'h0);
    req_tx = 1'b0;
    cyc(3);
    chk("no_ack_after_reset", {30'b0, ack_tx, vld_tx}, 32'h0);
    rstn = 1'b1;
    cyc(1);
    push_hex8_tail(8'h32);
    run_req(2'b01, 32'h0000_0002, 1'b0, 0, -1, 8);

    req_l = 1'b1; type_tx = 2'b01; dout = 32'h0000_000F; rdy_tx = 1'b1;
    cyc(1);
    dout = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) chk("lc_first", {23'b0, vld_l, d_l}, 32'h130);
      if (i == 7) chk("lc_last", {23'b0, vld_l, d_l}, 32'h166);
      cyc(1);
    end
    chk("lc_ack_rise", {31'b0, ack_l}, 32'h1);
    req_l = 1'b0;
    cyc(1);
    chk("lc_ack_fall", {31'b0, ack_l}, 32'h0);

    cyc(1);
    done = 1'b1;
  end

endmodule
